// File: rtl/mem_pkg.sv
// Shared definitions for the load/store unit: MIPS memory opcodes, access sizes,
// FSM states and the small decode helpers used by the datapath.
package mem_pkg;

    localparam logic [5:0] OPC_LB  = 6'b100000;
    localparam logic [5:0] OPC_LH  = 6'b100001;
    localparam logic [5:0] OPC_LW  = 6'b100011;
    localparam logic [5:0] OPC_LBU = 6'b100100;
    localparam logic [5:0] OPC_LHU = 6'b100101;
    localparam logic [5:0] OPC_SB  = 6'b101000;
    localparam logic [5:0] OPC_SH  = 6'b101001;
    localparam logic [5:0] OPC_SW  = 6'b101011;

    typedef enum logic [5:0] {
        OP_LB  = OPC_LB,
        OP_LH  = OPC_LH,
        OP_LW  = OPC_LW,
        OP_LBU = OPC_LBU,
        OP_LHU = OPC_LHU,
        OP_SB  = OPC_SB,
        OP_SH  = OPC_SH,
        OP_SW  = OPC_SW
    } mem_op_t;

    typedef enum logic [1:0] {
        SZ_NONE,
        SZ_BYTE,
        SZ_HALF,
        SZ_WORD
    } access_size_t;

    typedef enum logic {
        ST_IDLE,
        ST_RMW_WR
    } lsu_state_t;

    function automatic logic is_load(input logic [5:0] op);
        return op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
    endfunction

    function automatic logic is_store(input logic [5:0] op);
        return op inside {OP_SB, OP_SH, OP_SW};
    endfunction

    // Unknown opcodes map to SZ_NONE, which the unit treats as "no access".
    function automatic access_size_t access_size(input logic [5:0] op);
        case (op)
            OPC_LB, OPC_LBU, OPC_SB: return SZ_BYTE;
            OPC_LH, OPC_LHU, OPC_SH: return SZ_HALF;
            OPC_LW, OPC_SW:          return SZ_WORD;
            default:                 return SZ_NONE;
        endcase
    endfunction

endpackage

// File: rtl/byte_lane_merge.sv
// Little-endian lane helper: extracts and extends a byte/half for loads, and
// splices the low byte/half of store data into a word for read-modify-write.
module byte_lane_merge
    import mem_pkg::*;
(
    input  logic [31:0]  word,
    input  logic [1:0]   lane,
    input  access_size_t size,
    input  logic         sign_ext,
    input  logic [15:0]  store_val,
    output logic [31:0]  load_ext,
    output logic [31:0]  merged
);

    logic [4:0]  byte_shift;
    logic [4:0]  half_shift;
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        byte_shift = {lane, 3'b000};
        half_shift = {lane[1], 4'b0000};
        sel_byte   = 8'(word >> byte_shift);
        sel_half   = 16'(word >> half_shift);
        load_ext   = word;
        merged     = word;
        case (size)
            SZ_BYTE: begin
                load_ext = {{24{sign_ext & sel_byte[7]}}, sel_byte};
                merged   = (word & ~(32'h0000_00FF << byte_shift))
                         | ({24'b0, store_val[7:0]} << byte_shift);
            end
            SZ_HALF: begin
                load_ext = {{16{sign_ext & sel_half[15]}}, sel_half};
                merged   = (word & ~(32'h0000_FFFF << half_shift))
                         | ({16'b0, store_val} << half_shift);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit in front of a word-wide data memory: aligned
// loads with extension, direct SW, and SB/SH as a two-cycle read-modify-write.
module load_store_unit
    import mem_pkg::*;
#(
    parameter int MEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic [5:0]  op,
    input  logic [31:0] addr,
    input  logic [31:0] storeData,
    output logic        busy,
    output logic [31:0] loadData,
    output logic        loadValid,
    output logic        misaligned,
    output logic [31:0] memAddr,
    output logic [31:0] memWriteData,
    output logic        MemWrite,
    output logic        MemRead,
    input  logic [31:0] memReadData
);

    if (MEM_WORDS < 1) begin : g_bad_depth
        $error("load_store_unit: MEM_WORDS must be positive");
    end

    lsu_state_t   state, next_state;
    access_size_t size;
    logic         mis, go, go_load, go_sw, go_rmw;
    logic [29:0]  rmw_addr;
    logic [31:0]  rmw_data;
    logic [31:0]  load_ext, merged;

    always_comb begin
        size    = access_size(op);
        mis     = req && state == ST_IDLE
                  && ((size == SZ_WORD && addr[1:0] != 2'b00)
                   || (size == SZ_HALF && addr[0]));
        go      = req && state == ST_IDLE && size != SZ_NONE && !mis;
        go_load = go && is_load(op);
        go_sw   = go && op == OP_SW;
        go_rmw  = go && is_store(op) && size != SZ_WORD;
    end

    byte_lane_merge u_lane (
        .word      (memReadData),
        .lane      (addr[1:0]),
        .size      (size),
        .sign_ext  (op == OP_LB || op == OP_LH),
        .store_val (storeData[15:0]),
        .load_ext  (load_ext),
        .merged    (merged)
    );

    // NOTE: sequential state is always updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:   if (go_rmw) next_state = ST_RMW_WR;
            ST_RMW_WR: next_state = ST_IDLE;
            default:   next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        MemRead      = 1'b0;
        MemWrite     = 1'b0;
        busy         = 1'b0;
        memAddr      = {addr[31:2], 2'b00};
        memWriteData = storeData;
        case (state)
            ST_IDLE: begin
                MemRead  = go_load || go_rmw;
                MemWrite = go_sw;
                busy     = go_rmw;
            end
            ST_RMW_WR: begin
                MemWrite     = 1'b1;
                memAddr      = {rmw_addr, 2'b00};
                memWriteData = rmw_data;
            end
            default: ;
        endcase
        // Reset wins even mid-RMW so a half-finished merge never reaches memory.
        if (reset) begin
            MemRead  = 1'b0;
            MemWrite = 1'b0;
            busy     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            loadData   <= 32'b0;
            loadValid  <= 1'b0;
            misaligned <= 1'b0;
        end else begin
            loadValid  <= go_load;
            misaligned <= mis;
            if (go_load) loadData <= load_ext;
        end
    end

    // NOTE: the RMW capture registers are deliberately not reset; they are only read in RMW_WR, which is always entered through a capture.
    always_ff @(posedge clk) begin
        if (go_rmw) begin
            rmw_addr <= addr[31:2];
            rmw_data <= merged;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural word memory model.
module tb_load_store_unit;

    localparam logic [5:0] LB  = 6'b100000;
    localparam logic [5:0] LH  = 6'b100001;
    localparam logic [5:0] LW  = 6'b100011;
    localparam logic [5:0] LBU = 6'b100100;
    localparam logic [5:0] LHU = 6'b100101;
    localparam logic [5:0] SB  = 6'b101000;
    localparam logic [5:0] SH  = 6'b101001;
    localparam logic [5:0] SW  = 6'b101011;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic [5:0]  op;
    logic [31:0] addr;
    logic [31:0] storeData;
    logic        busy;
    logic [31:0] loadData;
    logic        loadValid;
    logic        misaligned;
    logic [31:0] memAddr;
    logic [31:0] memWriteData;
    logic        MemWrite;
    logic        MemRead;
    logic [31:0] memReadData;

    logic [31:0] mem [0:1023];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    load_store_unit #(.MEM_WORDS(1024)) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .op           (op),
        .addr         (addr),
        .storeData    (storeData),
        .busy         (busy),
        .loadData     (loadData),
        .loadValid    (loadValid),
        .misaligned   (misaligned),
        .memAddr      (memAddr),
        .memWriteData (memWriteData),
        .MemWrite     (MemWrite),
        .MemRead      (MemRead),
        .memReadData  (memReadData)
    );

    assign memReadData = MemRead ? mem[memAddr[11:2]] : 32'h0;

    always @(posedge clk) begin
        if (MemWrite) mem[memAddr[11:2]] <= memWriteData;
    end

    typedef struct {
        logic [5:0]  op;
        logic [31:0] addr;
        logic [31:0] data;
        logic        rd;
        logic        wr;
        logic        lv;
        logic [31:0] ld;
        logic        mis;
        logic        mchk;
        int          midx;
        logic [31:0] mval;
    } vec_t;

    vec_t vecs [15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic [5:0] o, input logic [31:0] a, input logic [31:0] d);
        req       = r;
        op        = o;
        addr      = a;
        storeData = d;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded its time budget");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        mem[1] = 32'h8899_AABB;

        vecs[0]  = '{LW,  32'd4, 32'h0,         1, 0, 1, 32'h8899_AABB, 0, 0, 0, 32'h0};
        vecs[1]  = '{LB,  32'd7, 32'h0,         1, 0, 1, 32'hFFFF_FF88, 0, 0, 0, 32'h0};
        vecs[2]  = '{LBU, 32'd7, 32'h0,         1, 0, 1, 32'h0000_0088, 0, 0, 0, 32'h0};
        vecs[3]  = '{LHU, 32'd6, 32'h0,         1, 0, 1, 32'h0000_8899, 0, 0, 0, 32'h0};
        vecs[4]  = '{LH,  32'd4, 32'h0,         1, 0, 1, 32'hFFFF_AABB, 0, 0, 0, 32'h0};
        vecs[5]  = '{LB,  32'd4, 32'h0,         1, 0, 1, 32'hFFFF_FFBB, 0, 0, 0, 32'h0};
        vecs[6]  = '{LBU, 32'd5, 32'h0,         1, 0, 1, 32'h0000_00AA, 0, 0, 0, 32'h0};
        vecs[7]  = '{LH,  32'd6, 32'h0,         1, 0, 1, 32'hFFFF_8899, 0, 0, 0, 32'h0};
        vecs[8]  = '{SW,  32'd8, 32'hDEAD_BEEF, 0, 1, 0, 32'h0,         0, 1, 2, 32'hDEAD_BEEF};
        vecs[9]  = '{LW,  32'd6, 32'h0,         0, 0, 0, 32'h0,         1, 1, 1, 32'h8899_AABB};
        vecs[10] = '{SH,  32'd3, 32'h0000_BEEF, 0, 0, 0, 32'h0,         1, 1, 0, 32'h0};
        vecs[11] = '{LH,  32'd5, 32'h0,         0, 0, 0, 32'h0,         1, 0, 0, 32'h0};
        vecs[12] = '{LW,  32'd2, 32'h0,         0, 0, 0, 32'h0,         1, 0, 0, 32'h0};
        vecs[13] = '{6'b000000, 32'd4, 32'h0,   0, 0, 0, 32'h0,         0, 0, 0, 32'h0};
        vecs[14] = '{LW,  32'd8, 32'h0,         1, 0, 1, 32'hDEAD_BEEF, 0, 0, 0, 32'h0};

        // Reset with a request present: no enables may leak out.
        reset = 1'b1;
        drive(1'b1, LW, 32'd4, 32'h0);
        tick();
        tick();
        check("reset MemRead", 32'(MemRead), 32'd0);
        check("reset MemWrite", 32'(MemWrite), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset loadValid", 32'(loadValid), 32'd0);
        check("reset misaligned", 32'(misaligned), 32'd0);
        check("reset loadData", loadData, 32'h0);
        reset = 1'b0;
        drive(1'b0, 6'b0, 32'h0, 32'h0);
        tick();

        // Single-cycle operations issued back to back.
        for (int i = 0; i < 15; i++) begin
            drive(1'b1, vecs[i].op, vecs[i].addr, vecs[i].data);
            #1;
            check($sformatf("v%0d MemRead", i), 32'(MemRead), 32'(vecs[i].rd));
            check($sformatf("v%0d MemWrite", i), 32'(MemWrite), 32'(vecs[i].wr));
            check($sformatf("v%0d busy", i), 32'(busy), 32'd0);
            check($sformatf("v%0d memAddr", i), memAddr, vecs[i].addr & ~32'd3);
            if (vecs[i].wr) check($sformatf("v%0d memWriteData", i), memWriteData, vecs[i].data);
            tick();
            check($sformatf("v%0d loadValid", i), 32'(loadValid), 32'(vecs[i].lv));
            check($sformatf("v%0d misaligned", i), 32'(misaligned), 32'(vecs[i].mis));
            if (vecs[i].lv) check($sformatf("v%0d loadData", i), loadData, vecs[i].ld);
            if (vecs[i].mchk) check($sformatf("v%0d mem word", i), mem[vecs[i].midx], vecs[i].mval);
        end

        // SB addr 5 then a back-to-back LW of the same word.
        drive(1'b1, SB, 32'd5, 32'h1234_56CC);
        #1;
        check("sb accept busy", 32'(busy), 32'd1);
        check("sb accept MemRead", 32'(MemRead), 32'd1);
        check("sb accept MemWrite", 32'(MemWrite), 32'd0);
        tick();
        check("sb rmw busy", 32'(busy), 32'd0);
        check("sb rmw MemWrite", 32'(MemWrite), 32'd1);
        check("sb rmw MemRead", 32'(MemRead), 32'd0);
        check("sb rmw memAddr", memAddr, 32'd4);
        check("sb rmw memWriteData", memWriteData, 32'h8899_CCBB);
        check("sb rmw loadValid", 32'(loadValid), 32'd0);
        tick();
        check("sb mem word", mem[1], 32'h8899_CCBB);
        drive(1'b1, LW, 32'd4, 32'h0);
        #1;
        check("lw after sb MemRead", 32'(MemRead), 32'd1);
        tick();
        check("lw after sb loadValid", 32'(loadValid), 32'd1);
        check("lw after sb loadData", loadData, 32'h8899_CCBB);

        // SH addr 2 into word 0.
        drive(1'b1, SH, 32'd2, 32'h0000_BEEF);
        #1;
        check("sh accept busy", 32'(busy), 32'd1);
        tick();
        check("sh rmw MemWrite", 32'(MemWrite), 32'd1);
        check("sh rmw memWriteData", memWriteData, 32'hBEEF_0000);
        tick();
        drive(1'b0, 6'b0, 32'h0, 32'h0);
        check("sh mem word", mem[0], 32'hBEEF_0000);

        // Reset lands during RMW_WR of an SB: the merge must be dropped.
        drive(1'b1, SB, 32'd8, 32'h0000_0011);
        #1;
        check("sb2 accept busy", 32'(busy), 32'd1);
        tick();
        reset = 1'b1;
        #1;
        check("rst rmw MemWrite", 32'(MemWrite), 32'd0);
        check("rst rmw MemRead", 32'(MemRead), 32'd0);
        check("rst rmw busy", 32'(busy), 32'd0);
        tick();
        check("rst rmw mem word", mem[2], 32'hDEAD_BEEF);
        check("rst rmw loadData", loadData, 32'h0);
        check("rst rmw loadValid", 32'(loadValid), 32'd0);
        check("rst rmw misaligned", 32'(misaligned), 32'd0);
        reset = 1'b0;
        drive(1'b1, LW, 32'd8, 32'h0);
        #1;
        check("post rst MemRead", 32'(MemRead), 32'd1);
        check("post rst MemWrite", 32'(MemWrite), 32'd0);
        check("post rst busy", 32'(busy), 32'd0);
        tick();
        drive(1'b0, 6'b0, 32'h0, 32'h0);
        check("post rst loadValid", 32'(loadValid), 32'd1);
        check("post rst loadData", loadData, 32'hDEAD_BEEF);
        tick();
        check("loadValid pulse ends", 32'(loadValid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
